// File: rtl/gray_scan_pkg.sv
// Shared definitions for the Gray-code scan controller: FSM encoding, code width and
// delta classes.
package gray_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_DECODE  = 2'd2,
        S_PRESENT = 2'd3
    } state_e;

    localparam int unsigned GW = 4;

    localparam logic [GW-1:0] D_NONE = 4'd0;
    localparam logic [GW-1:0] D_UP   = 4'd1;
    localparam logic [GW-1:0] D_DOWN = 4'd15;

endpackage

// File: rtl/gray_scan_ctrl_deco1.sv
// 4-bit Gray-to-binary decoder. It is purely combinational.
module Deco1
    import gray_scan_pkg::*;
(
    input  logic [GW-1:0] g_i,
    output logic [GW-1:0] b_o
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    assign b_o = {g_i[3], g_i[3] ^ g_i[2], ^g_i[3:1], ^g_i[3:0]};

endmodule

// File: rtl/gray_scan_ctrl.sv
// Round-robin scanner that uses one shared Gray decoder for NCH channels. It emits
// step/jump events on a valid/ready interface.
module gray_scan_ctrl
    import gray_scan_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    localparam int unsigned PW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [GW*NCH-1:0] gray_in,
    input  logic              scan_en,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [PW-1:0]     out_ch,
    output logic [GW-1:0]     out_bin,
    output logic              out_dir,
    output logic              out_err,
    output logic              busy
);

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [GW-1:0]   g_q;
    logic [GW-1:0]   last_q [NCH];
    logic [NCH-1:0]  primed_q;
    logic [PW-1:0]   out_ch_q;
    logic [GW-1:0]   out_bin_q;
    logic            out_dir_q;
    logic            out_err_q;

    logic [GW-1:0]   bin;
    logic [GW-1:0]   delta;
    logic [GW-1:0]   g_sel;
    logic [PW-1:0]   ptr_nxt;

    Deco1 u_deco (
        .g_i (g_q),
        .b_o (bin)
    );

    always_comb begin
        g_sel   = gray_in[GW*ptr_q +: GW];
        delta   = bin - last_q[ptr_q];
        ptr_nxt = (ptr_q == PW'(NCH - 1)) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            g_q       <= '0;
            primed_q  <= '0;
            out_ch_q  <= '0;
            out_bin_q <= '0;
            out_dir_q <= 1'b0;
            out_err_q <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                last_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (scan_en) state_q <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    g_q     <= g_sel;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (!primed_q[ptr_q] || delta == D_NONE) begin
                        // First look at a channel only records its position.
                        if (!primed_q[ptr_q]) begin
                            last_q[ptr_q]   <= bin;
                            primed_q[ptr_q] <= 1'b1;
                        end
                        ptr_q   <= ptr_nxt;
                        state_q <= scan_en ? S_SAMPLE : S_IDLE;
                    end else begin
                        out_ch_q  <= ptr_q;
                        out_bin_q <= bin;
                        out_dir_q <= (delta == D_UP);
                        out_err_q <= (delta != D_UP) && (delta != D_DOWN);
                        state_q   <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        last_q[ptr_q] <= out_bin_q;
                        ptr_q         <= ptr_nxt;
                        state_q       <= scan_en ? S_SAMPLE : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == S_PRESENT);
    assign busy      = (state_q != S_IDLE);
    assign out_ch    = out_ch_q;
    assign out_bin   = out_bin_q;
    assign out_dir   = out_dir_q;
    assign out_err   = out_err_q;

endmodule
